apb_master: RTL and testbench

APB requester (bridge) that converts a simple valid/ready command channel into APB SETUP/ACCESS transfers toward the register-bank completers on the same PCLK domain. It accepts one command at a time and sequences PSEL/PENABLE. It honours PREADY wait states, then returns read data and PSLVERR on a valid/ready response channel. It is the initiator end of the same APB link the register bank serves.

---
 rtl/apb_master_if.sv | 38 +++
 rtl/apb_master.sv | 141 ++++++++++++++
 tb/tb_apb_master.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/apb_master_if.sv
// Command, response and APB signal bundle between the APB requester and its users.
// The master modport is the requester's view; slave is the opposite side (command source plus completer).
interface apb_master_if #(
   parameter int AWIDTH = 4,
   parameter int DWIDTH = 8
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [AWIDTH-1:0] cmd_addr;
   logic [DWIDTH-1:0] cmd_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DWIDTH-1:0] rsp_rdata;
   logic              rsp_err;
   logic              rsp_timeout;
   logic              busy;
   logic              PSEL;
   logic              PENABLE;
   logic              PWRITE;
   logic [AWIDTH-1:0] PADDR;
   logic [DWIDTH-1:0] PWDATA;
   logic [DWIDTH-1:0] PRDATA;
   logic              PREADY;
   logic              PSLVERR;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY, PSLVERR,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
             PSEL, PENABLE, PWRITE, PADDR, PWDATA
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY, PSLVERR,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
             PSEL, PENABLE, PWRITE, PADDR, PWDATA
   );
endinterface

// File: rtl/apb_master.sv
// APB requester: one valid/ready command becomes one SETUP/ACCESS transfer, answered on a response channel.
// Optional PREADY timeout abort is built only when APB_TIMEOUT_EN is defined.
module apb_master #(
   parameter int AWIDTH         = 4,
   parameter int DWIDTH         = 8,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic         PCLK,
   input  logic         PRESET,
   apb_master_if.master bus
);
   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

   state_t            r_state, w_next_state;
   logic              r_cmd_ready, w_cmd_ready;
   logic              r_psel, w_psel;
   logic              r_penable, w_penable;
   logic              r_pwrite, w_pwrite;
   logic [AWIDTH-1:0] r_paddr, w_paddr;
   logic [DWIDTH-1:0] r_pwdata, w_pwdata;
   logic              r_rsp_valid, w_rsp_valid;
   logic [DWIDTH-1:0] r_rsp_rdata, w_rsp_rdata;
   logic              r_rsp_err, w_rsp_err;
   logic              r_rsp_timeout, w_rsp_timeout;
   logic              r_busy, w_busy;
   logic              w_timeout_hit;

`ifdef APB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] r_to_cnt;

   // Held at zero outside ACCESS, so it is clear on every entry to ACCESS.
   always_ff @(posedge PCLK) begin
      if (PRESET || r_state != S_ACCESS) begin
         r_to_cnt <= '0;
      end else if (!bus.PREADY) begin
         r_to_cnt <= r_to_cnt + 1'b1;
      end
   end

   assign w_timeout_hit = (r_state == S_ACCESS) && !bus.PREADY &&
                          (r_to_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
   // No abort path: the limit is never negative, so this is constant false.
   assign w_timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state  = r_state;
      w_pwrite      = r_pwrite;
      w_paddr       = r_paddr;
      w_pwdata      = r_pwdata;
      w_rsp_rdata   = r_rsp_rdata;
      w_rsp_err     = r_rsp_err;
      w_rsp_timeout = r_rsp_timeout;
      case (r_state)
         S_IDLE: begin
            if (bus.cmd_valid && r_cmd_ready) begin
               w_next_state = S_SETUP;
               w_pwrite     = bus.cmd_write;
               w_paddr      = bus.cmd_addr;
               w_pwdata     = bus.cmd_write ? bus.cmd_wdata : '0;
            end
         end
         S_SETUP: w_next_state = S_ACCESS;
         S_ACCESS: begin
            if (bus.PREADY) begin
               w_next_state  = S_RESP;
               w_rsp_rdata   = r_pwrite ? '0 : bus.PRDATA;
               w_rsp_err     = bus.PSLVERR;
               w_rsp_timeout = 1'b0;
            end else if (w_timeout_hit) begin
               w_next_state  = S_RESP;
               w_rsp_rdata   = '0;
               w_rsp_err     = 1'b1;
               w_rsp_timeout = 1'b1;
            end
         end
         S_RESP: begin
            if (r_rsp_valid && bus.rsp_ready) begin
               w_next_state = S_IDLE;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
      // Outputs are registered copies of what the next state presents.
      w_cmd_ready = (w_next_state == S_IDLE);
      w_psel      = (w_next_state == S_SETUP) || (w_next_state == S_ACCESS);
      w_penable   = (w_next_state == S_ACCESS);
      w_rsp_valid = (w_next_state == S_RESP);
      w_busy      = (w_next_state != S_IDLE);
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_cmd_ready   <= 1'b0;
         r_psel        <= 1'b0;
         r_penable     <= 1'b0;
         r_pwrite      <= 1'b0;
         r_paddr       <= '0;
         r_pwdata      <= '0;
         r_rsp_valid   <= 1'b0;
         r_rsp_rdata   <= '0;
         r_rsp_err     <= 1'b0;
         r_rsp_timeout <= 1'b0;
         r_busy        <= 1'b0;
      end else begin
         r_cmd_ready   <= w_cmd_ready;
         r_psel        <= w_psel;
         r_penable     <= w_penable;
         r_pwrite      <= w_pwrite;
         r_paddr       <= w_paddr;
         r_pwdata      <= w_pwdata;
         r_rsp_valid   <= w_rsp_valid;
         r_rsp_rdata   <= w_rsp_rdata;
         r_rsp_err     <= w_rsp_err;
         r_rsp_timeout <= w_rsp_timeout;
         r_busy        <= w_busy;
      end
   end

   assign bus.cmd_ready   = r_cmd_ready;
   assign bus.PSEL        = r_psel;
   assign bus.PENABLE     = r_penable;
   assign bus.PWRITE      = r_pwrite;
   assign bus.PADDR       = r_paddr;
   assign bus.PWDATA      = r_pwdata;
   assign bus.rsp_valid   = r_rsp_valid;
   assign bus.rsp_rdata   = r_rsp_rdata;
   assign bus.rsp_err     = r_rsp_err;
   assign bus.rsp_timeout = r_rsp_timeout;
   assign bus.busy        = r_busy;
endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: stimulus pushes expected responses, a monitor pops them on each response handshake.
// Cycle-exact APB phase checks run inside the stimulus task; the completer model lives in its own process.
module tb_apb_master;
   localparam int AW = 4;
   localparam int DW = 8;
   localparam int TO = 16;

   logic PCLK   = 1'b0;
   logic PRESET = 1'b1;

   apb_master_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

   apb_master #(.AWIDTH(AW), .DWIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
      .PCLK   (PCLK),
      .PRESET (PRESET),
      .bus    (bus)
   );

   always #5 PCLK = ~PCLK;

   typedef struct packed {
      logic [7:0] rdata;
      logic       err;
      logic       to;
   } rsp_t;

   rsp_t       exp_q[$];
   rsp_t       mon_e;
   int         n_checks = 0;
   int         n_pass   = 0;
   int         n_rsp    = 0;
   int         cfg_waits = 0;
   logic [7:0] cfg_rdata = 8'h00;
   logic       cfg_err   = 1'b0;
   int         wait_ctr  = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Completer: PREADY rises after cfg_waits low ACCESS cycles; junk data/error otherwise.
   initial begin
      bus.PREADY  = 1'b0;
      bus.PRDATA  = 8'hEE;
      bus.PSLVERR = 1'b1;
      forever begin
         @(negedge PCLK);
         if (bus.PSEL && bus.PENABLE) begin
            if (wait_ctr == cfg_waits) begin
               bus.PREADY = 1'b1; bus.PRDATA = cfg_rdata; bus.PSLVERR = cfg_err;
            end else begin
               bus.PREADY = 1'b0; bus.PRDATA = 8'hEE; bus.PSLVERR = 1'b1;
            end
            wait_ctr++;
         end else begin
            wait_ctr = 0;
            bus.PREADY = 1'b0; bus.PRDATA = 8'hEE; bus.PSLVERR = 1'b1;
         end
      end
   end

   // Response monitor: compares against the scoreboard whenever a handshake is about to happen.
   initial begin
      forever begin
         @(negedge PCLK);
         #1;
         if (!PRESET && bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_rsp", 1, 0);
            end else begin
               mon_e = exp_q.pop_front();
               n_rsp++;
               $display("rsp %0d: rdata=0x%02h err=%0b timeout=%0b (exp 0x%02h %0b %0b)", n_rsp,
                        bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout, mon_e.rdata, mon_e.err, mon_e.to);
               chk("rsp_rdata", bus.rsp_rdata, mon_e.rdata);
               chk("rsp_err", bus.rsp_err, mon_e.err);
               chk("rsp_timeout", bus.rsp_timeout, mon_e.to);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic xfer(input string tag, input logic w, input logic [3:0] a, input logic [7:0] d,
                       input int waits, input logic [7:0] rd, input logic er, input logic exp_to,
                       input int stall, input logic chain,
                       input logic cw, input logic [3:0] ca, input logic [7:0] cd);
      rsp_t       e;
      int         acc;
      int         t;
      logic [7:0] wd;
      e.rdata = (w || exp_to) ? 8'h00 : rd;
      e.err   = er | exp_to;
      e.to    = exp_to;
      acc     = exp_to ? TO : waits + 1;
      wd      = w ? d : 8'h00;
      cfg_waits = waits; cfg_rdata = rd; cfg_err = er;
      t = 0;
      while (!bus.cmd_ready && t < 64) begin @(negedge PCLK); t++; end
      chk({tag, "_cmd_ready"}, bus.cmd_ready, 1);
      exp_q.push_back(e);
      bus.rsp_ready = (stall == 0);
      bus.cmd_valid = 1'b1; bus.cmd_write = w; bus.cmd_addr = a; bus.cmd_wdata = d;
      @(negedge PCLK);
      if (chain) begin
         bus.cmd_write = cw; bus.cmd_addr = ca; bus.cmd_wdata = cd;
      end else begin
         bus.cmd_valid = 1'b0; bus.cmd_write = ~w; bus.cmd_addr = ~a; bus.cmd_wdata = ~d;
      end
      chk({tag, "_setup"}, {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA, bus.cmd_ready, bus.busy},
          {1'b1, 1'b0, w, a, wd, 1'b0, 1'b1});
      for (int i = 0; i < acc; i++) begin
         @(negedge PCLK);
         chk({tag, "_access"}, {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA, bus.rsp_valid},
             {1'b1, 1'b1, w, a, wd, 1'b0});
      end
      @(negedge PCLK);
      chk({tag, "_resp"}, {bus.rsp_valid, bus.PSEL, bus.PENABLE, bus.busy, bus.cmd_ready},
          {1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
      $display("xfer %s: write=%0b addr=0x%0h wdata=0x%02h waits=%0d access_cycles=%0d", tag, w, a, d, waits, acc);
      for (int i = 0; i < stall; i++) begin
         chk({tag, "_stall"}, {bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout, bus.PSEL, bus.cmd_ready},
             {1'b1, e.rdata, e.err, e.to, 1'b0, 1'b0});
         @(negedge PCLK);
      end
      bus.rsp_ready = 1'b1;
      @(negedge PCLK);
      chk({tag, "_done"}, {bus.rsp_valid, bus.cmd_ready, bus.busy, bus.PSEL}, {1'b0, 1'b1, 1'b0, 1'b0});
   endtask

   initial begin
      bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = 4'h0; bus.cmd_wdata = 8'h00;
      bus.rsp_ready = 1'b1;
      PRESET = 1'b1;
      repeat (3) @(negedge PCLK);
      chk("reset_outputs", {bus.cmd_ready, bus.rsp_valid, bus.busy, bus.PSEL, bus.PENABLE, bus.PWRITE,
                            bus.PADDR, bus.PWDATA, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout}, 0);
      PRESET = 1'b0;
      @(negedge PCLK);
      chk("reset_release_ready", {bus.cmd_ready, bus.busy}, {1'b1, 1'b0});

      xfer("wr",        1'b1, 4'h2, 8'hA5, 0, 8'h5A, 1'b0, 1'b0, 0, 1'b0, 1'b0, 4'h0, 8'h00);
      xfer("rd_wait",   1'b0, 4'h6, 8'h00, 3, 8'h3C, 1'b0, 1'b0, 0, 1'b0, 1'b0, 4'h0, 8'h00);
      xfer("rd_err",    1'b0, 4'hF, 8'h00, 0, 8'h77, 1'b1, 1'b0, 0, 1'b0, 1'b0, 4'h0, 8'h00);
      xfer("after_err", 1'b1, 4'h3, 8'h81, 1, 8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b0, 4'h0, 8'h00);
      xfer("stall",     1'b1, 4'h9, 8'hC3, 0, 8'h11, 1'b0, 1'b0, 5, 1'b1, 1'b0, 4'h4, 8'h00);
      xfer("chained",   1'b0, 4'h4, 8'h00, 2, 8'hD2, 1'b0, 1'b0, 0, 1'b0, 1'b0, 4'h0, 8'h00);

      // Reset in the second ACCESS wait cycle: the transfer and its response vanish.
      cfg_waits = 10; cfg_rdata = 8'h66; cfg_err = 1'b0;
      bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 4'h4;
      @(negedge PCLK);
      bus.cmd_valid = 1'b0;
      @(negedge PCLK);
      @(negedge PCLK);
      chk("midrst_in_access", {bus.PSEL, bus.PENABLE}, {1'b1, 1'b1});
      PRESET = 1'b1;
      @(negedge PCLK);
      chk("midrst_outputs", {bus.PSEL, bus.PENABLE, bus.rsp_valid, bus.busy, bus.cmd_ready}, 0);
      PRESET = 1'b0;
      @(negedge PCLK);
      chk("midrst_release", {bus.cmd_ready, bus.rsp_valid, bus.PSEL}, {1'b1, 1'b0, 1'b0});
      $display("xfer midrst: read addr=0x4 aborted by reset");

      xfer("post_rst",  1'b0, 4'h1, 8'h00, 0, 8'h4B, 1'b0, 1'b0, 0, 1'b0, 1'b0, 4'h0, 8'h00);
`ifdef APB_TIMEOUT_EN
      xfer("timeout",   1'b0, 4'h5, 8'h00, 1000, 8'h99, 1'b0, 1'b1, 0, 1'b0, 1'b0, 4'h0, 8'h00);
      xfer("limit_ok",  1'b0, 4'h5, 8'h00, TO - 1, 8'h99, 1'b0, 1'b0, 0, 1'b0, 1'b0, 4'h0, 8'h00);
`else
      xfer("long_wait", 1'b0, 4'h5, 8'h00, 20, 8'h99, 1'b0, 1'b0, 0, 1'b0, 1'b0, 4'h0, 8'h00);
`endif
      repeat (2) @(negedge PCLK);
      chk("queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
